// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the memory-stage access controller.
// The timeout feature (MEM_ACCESS_TIMEOUT_EN) lives in mem_stage_access_ctrl.sv.
package mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // True when funct3 is a legal encoding for the direction and the lane is naturally aligned.
    function automatic logic access_ok(input logic       is_store,
                                       input logic [2:0] funct3,
                                       input logic [1:0] lane);
        logic legal;
        logic aligned;
        legal   = 1'b0;
        aligned = 1'b1;
        case (funct3)
            F3_B:  legal = 1'b1;
            F3_H:  begin legal = 1'b1;      aligned = ~lane[0];          end
            F3_W:  begin legal = 1'b1;      aligned = (lane == 2'b00);   end
            F3_BU: legal = ~is_store;
            F3_HU: begin legal = ~is_store; aligned = ~lane[0];          end
            default: legal = 1'b0;
        endcase
        return legal & aligned;
    endfunction

endpackage

// File: rtl/mem_stage_access_ctrl_load_align.sv
// Combinational load extractor: selects the byte/halfword lane of a read word
// and sign- or zero-extends it according to funct3.
module load_align_unit
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[{i_addr, 3'b000} +: 8];
        w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_BU:   o_data = {24'h0, w_byte};
            F3_HU:   o_data = {16'h0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_access_ctrl.sv
// Memory-stage controller: drives the data-memory request/ready bus, aligns stores and loads,
// stalls the front pipeline while busy. Optional REQ timeout: define MEM_ACCESS_TIMEOUT_EN.
module mem_stage_access_ctrl
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        IN_DATAMEMSEL,
    input  logic [3:0]  IN_READ_WRITE,
    input  logic [31:0] IN_ALU_RESULT,
    input  logic [31:0] IN_DATA2,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    output logic [3:0]  MEM_WSTRB,
    input  logic [31:0] MEM_RDATA,
    input  logic        MEM_READY,
    input  logic        MEM_ERR,
    output logic [31:0] OUT_LOAD_DATA,
    output logic        OUT_LOAD_VALID,
    output logic        OUT_STALL,
    output logic        OUT_FAULT
);

    state_t      r_state;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [1:0]  r_lane;
    logic [2:0]  r_f3;
    logic [31:0] r_load_data;
    logic        r_load_valid;
    logic        r_fault;

    logic        w_is_store;
    logic [2:0]  w_f3;
    logic [1:0]  w_lane;
    logic        w_ok;
    logic        w_start;
    logic        w_idle_fault;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic [31:0] w_load_data;
    logic        w_timeout;

    assign w_is_store   = IN_READ_WRITE[3];
    assign w_f3         = IN_READ_WRITE[2:0];
    assign w_lane       = IN_ALU_RESULT[1:0];
    assign w_ok         = access_ok(w_is_store, w_f3, w_lane);
    assign w_start      = (r_state == IDLE) && IN_DATAMEMSEL && w_ok;
    assign w_idle_fault = (r_state == IDLE) && IN_DATAMEMSEL && !w_ok;

    // Combinational outputs are gated by reset so an asserted reset silences them immediately.
    assign OUT_STALL = RESET_N && (w_start || (r_state == REQ));
    assign OUT_FAULT = r_fault || (RESET_N && w_idle_fault);

    assign MEM_REQ        = r_req;
    assign MEM_WE         = r_we;
    assign MEM_ADDR       = r_addr;
    assign MEM_WDATA      = r_wdata;
    assign MEM_WSTRB      = r_wstrb;
    assign OUT_LOAD_DATA  = r_load_data;
    assign OUT_LOAD_VALID = r_load_valid;

    always_comb begin
        w_wdata = IN_DATA2;
        w_wstrb = STRB_W;
        case (w_f3[1:0])
            2'b00: begin
                w_wdata = {4{IN_DATA2[7:0]}};
                w_wstrb = STRB_B << w_lane;
            end
            2'b01: begin
                w_wdata = {2{IN_DATA2[15:0]}};
                w_wstrb = STRB_H << w_lane;
            end
            default: begin
                w_wdata = IN_DATA2;
                w_wstrb = STRB_W;
            end
        endcase
        if (!w_is_store) begin
            w_wstrb = '0;
        end
    end

    load_align_unit u_load_align (
        .i_rdata  (MEM_RDATA),
        .i_addr   (r_lane),
        .i_funct3 (r_f3),
        .o_data   (w_load_data)
    );

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;

    // Abort on the REQ cycle whose increment would bring the count to TIMEOUT_CYCLES.
    assign w_timeout = (r_state == REQ) && !MEM_READY &&
                       (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt <= '0;
        end else if (w_start) begin
            r_cnt <= '0;
        end else if ((r_state == REQ) && !MEM_READY) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state      <= IDLE;
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_lane       <= '0;
            r_f3         <= '0;
            r_load_data  <= '0;
            r_load_valid <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_load_valid <= 1'b0;
            r_fault      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_req   <= 1'b1;
                        r_we    <= w_is_store;
                        r_addr  <= {IN_ALU_RESULT[31:2], 2'b00};
                        r_wdata <= w_wdata;
                        r_wstrb <= w_wstrb;
                        r_lane  <= w_lane;
                        r_f3    <= w_f3;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (MEM_READY) begin
                        r_req   <= 1'b0;
                        r_state <= RESP;
                        if (MEM_ERR) begin
                            r_fault <= 1'b1;
                        end else if (!r_we) begin
                            r_load_data  <= w_load_data;
                            r_load_valid <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_req   <= 1'b0;
                        r_fault <= 1'b1;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_access_ctrl.sv
// Scoreboard bench for mem_stage_access_ctrl: stimulus queues expected bus requests,
// load results and faults; a negedge monitor pops and compares as the DUT presents them.
module tb_mem_stage_access_ctrl;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        IN_DATAMEMSEL;
    logic [3:0]  IN_READ_WRITE;
    logic [31:0] IN_ALU_RESULT;
    logic [31:0] IN_DATA2;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [3:0]  MEM_WSTRB;
    logic [31:0] MEM_RDATA;
    logic        MEM_READY;
    logic        MEM_ERR;
    logic [31:0] OUT_LOAD_DATA;
    logic        OUT_LOAD_VALID;
    logic        OUT_STALL;
    logic        OUT_FAULT;

    mem_stage_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .CLK            (CLK),
        .RESET_N        (RESET_N),
        .IN_DATAMEMSEL  (IN_DATAMEMSEL),
        .IN_READ_WRITE  (IN_READ_WRITE),
        .IN_ALU_RESULT  (IN_ALU_RESULT),
        .IN_DATA2       (IN_DATA2),
        .MEM_REQ        (MEM_REQ),
        .MEM_WE         (MEM_WE),
        .MEM_ADDR       (MEM_ADDR),
        .MEM_WDATA      (MEM_WDATA),
        .MEM_WSTRB      (MEM_WSTRB),
        .MEM_RDATA      (MEM_RDATA),
        .MEM_READY      (MEM_READY),
        .MEM_ERR        (MEM_ERR),
        .OUT_LOAD_DATA  (OUT_LOAD_DATA),
        .OUT_LOAD_VALID (OUT_LOAD_VALID),
        .OUT_STALL      (OUT_STALL),
        .OUT_FAULT      (OUT_FAULT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        we;
        logic        chk_wdata;
    } bus_t;

    bus_t        q_bus[$];
    logic [31:0] q_load[$];
    logic [31:0] q_fault[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=present expected=none", name);
    endtask

    // Monitor / scoreboard
    initial begin
        logic prev_req;
        bus_t b;
        logic [31:0] e;
        prev_req = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RESET_N) begin
                prev_req = 1'b0;
            end else begin
                if (MEM_REQ && !prev_req) begin
                    if (q_bus.size() == 0) unexpected("unexpected_req");
                    else begin
                        b = q_bus.pop_front();
                        chk("req_addr", MEM_ADDR, b.addr);
                        chk("req_wstrb", {28'h0, MEM_WSTRB}, {28'h0, b.strb});
                        chk("req_we", {31'h0, MEM_WE}, {31'h0, b.we});
                        if (b.chk_wdata) chk("req_wdata", MEM_WDATA, b.wdata);
                    end
                end
                if (OUT_LOAD_VALID) begin
                    if (q_load.size() == 0) unexpected("unexpected_load_valid");
                    else begin
                        e = q_load.pop_front();
                        chk("load_data", OUT_LOAD_DATA, e);
                        chk("load_no_fault", {31'h0, OUT_FAULT}, 32'h0);
                    end
                end
                if (OUT_FAULT) begin
                    if (q_fault.size() == 0) unexpected("unexpected_fault");
                    else begin
                        e = q_fault.pop_front();
                        chk("fault_load_held", OUT_LOAD_DATA, e);
                        chk("fault_stall", {31'h0, OUT_STALL}, 32'h0);
                        chk("fault_req", {31'h0, MEM_REQ}, 32'h0);
                    end
                end
                prev_req = MEM_REQ;
            end
        end
    end

    task automatic push_bus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s,
                            input logic we, input logic cw);
        bus_t b;
        b.addr = a; b.wdata = wd; b.strb = s; b.we = we; b.chk_wdata = cw;
        q_bus.push_back(b);
    endtask

    // Presents one access at #1 after a rising edge and plays the memory side.
    // ready_at: REQ cycle (1-based) in which MEM_READY is returned; 0 means never.
    task automatic access(input string nm, input logic [3:0] rw, input logic [31:0] addr,
                          input logic [31:0] data, input int ready_at, input logic [31:0] rdata,
                          input logic err, input int exp_stall, input logic exp_lv);
        int reqc;
        int nst;
        bit done;
        reqc = 0; nst = 0; done = 1'b0;
        IN_DATAMEMSEL = 1'b1;
        IN_READ_WRITE = rw;
        IN_ALU_RESULT = addr;
        IN_DATA2      = data;
        for (int k = 0; k < 200 && !done; k++) begin
            if (MEM_REQ) reqc++;
            MEM_READY = MEM_REQ && (reqc == ready_at);
            MEM_RDATA = MEM_READY ? rdata : 32'h0BAD_0BAD;
            MEM_ERR   = MEM_READY && err;
            @(negedge CLK);
            if (OUT_STALL) nst++;
            else begin
                done = 1'b1;
                chk({nm, "_valid"}, {31'h0, OUT_LOAD_VALID}, {31'h0, exp_lv});
            end
            if (!done) begin
                @(posedge CLK);
                #1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=stuck expected=finish", nm);
        end
        chk({nm, "_stalls"}, nst, exp_stall);
        @(posedge CLK);
        #1;
        IN_DATAMEMSEL = 1'b0;
        MEM_READY     = 1'b0;
        MEM_ERR       = 1'b0;
    endtask

    initial begin
        RESET_N       = 1'b0;
        IN_DATAMEMSEL = 1'b0;
        IN_READ_WRITE = '0;
        IN_ALU_RESULT = '0;
        IN_DATA2      = '0;
        MEM_RDATA     = '0;
        MEM_READY     = 1'b0;
        MEM_ERR       = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_req", {31'h0, MEM_REQ}, 32'h0);
        chk("rst_we", {31'h0, MEM_WE}, 32'h0);
        chk("rst_wstrb", {28'h0, MEM_WSTRB}, 32'h0);
        chk("rst_addr", MEM_ADDR, 32'h0);
        chk("rst_wdata", MEM_WDATA, 32'h0);
        chk("rst_load", OUT_LOAD_DATA, 32'h0);
        chk("rst_valid", {31'h0, OUT_LOAD_VALID}, 32'h0);
        chk("rst_fault", {31'h0, OUT_FAULT}, 32'h0);
        chk("rst_stall", {31'h0, OUT_STALL}, 32'h0);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;

        // Loads
        push_bus(32'h100, 0, 4'b0000, 1'b0, 1'b0); q_load.push_back(32'hDEADBEEF);
        access("lw", 4'b0010, 32'h100, 0, 1, 32'hDEADBEEF, 1'b0, 2, 1'b1);
        push_bus(32'h100, 0, 4'b0000, 1'b0, 1'b0); q_load.push_back(32'hFFFFFF80);
        access("lb", 4'b0000, 32'h103, 0, 1, 32'h80123456, 1'b0, 2, 1'b1);
        push_bus(32'h100, 0, 4'b0000, 1'b0, 1'b0); q_load.push_back(32'h00000080);
        access("lbu", 4'b0100, 32'h103, 0, 1, 32'h80123456, 1'b0, 2, 1'b1);
        push_bus(32'h100, 0, 4'b0000, 1'b0, 1'b0); q_load.push_back(32'h00008012);
        access("lhu", 4'b0101, 32'h102, 0, 1, 32'h80123456, 1'b0, 2, 1'b1);
        push_bus(32'h100, 0, 4'b0000, 1'b0, 1'b0); q_load.push_back(32'hFFFF8012);
        access("lh_hi", 4'b0001, 32'h102, 0, 1, 32'h80123456, 1'b0, 2, 1'b1);
        push_bus(32'h100, 0, 4'b0000, 1'b0, 1'b0); q_load.push_back(32'h00007FFF);
        access("lh_lo", 4'b0001, 32'h100, 0, 2, 32'h12347FFF, 1'b0, 3, 1'b1);
        push_bus(32'h100, 0, 4'b0000, 1'b0, 1'b0); q_load.push_back(32'hFFFFFFF0);
        access("lb_l1", 4'b0000, 32'h101, 0, 1, 32'h1234F0AB, 1'b0, 2, 1'b1);

        // Stores
        push_bus(32'h204, 32'hABCDABCD, 4'b1100, 1'b1, 1'b1);
        access("sh", 4'b1001, 32'h206, 32'h0000ABCD, 1, 0, 1'b0, 2, 1'b0);
        push_bus(32'h300, 32'h5A5A5A5A, 4'b0010, 1'b1, 1'b1);
        access("sb", 4'b1000, 32'h301, 32'h1234565A, 1, 0, 1'b0, 2, 1'b0);
        push_bus(32'h40C, 32'hCAFEF00D, 4'b1111, 1'b1, 1'b1);
        access("sw", 4'b1010, 32'h40C, 32'hCAFEF00D, 3, 0, 1'b0, 4, 1'b0);

        // Misaligned / illegal: fault in cycle 0, no request, no stall
        q_fault.push_back(32'hFFFFFFF0);
        access("lw_mis", 4'b0010, 32'h101, 0, 1, 0, 1'b0, 0, 1'b0);
        q_fault.push_back(32'hFFFFFFF0);
        access("st_f3_011", 4'b1011, 32'h200, 32'h11111111, 1, 0, 1'b0, 0, 1'b0);
        q_fault.push_back(32'hFFFFFFF0);
        access("ld_f3_110", 4'b0110, 32'h300, 0, 1, 0, 1'b0, 0, 1'b0);
        q_fault.push_back(32'hFFFFFFF0);
        access("sh_mis", 4'b1001, 32'h203, 32'h22222222, 1, 0, 1'b0, 0, 1'b0);
        q_fault.push_back(32'hFFFFFFF0);
        access("st_f3_100", 4'b1100, 32'h200, 32'h33333333, 1, 0, 1'b0, 0, 1'b0);

        // Delayed bus error
        push_bus(32'h500, 0, 4'b0000, 1'b0, 1'b0); q_fault.push_back(32'hFFFFFFF0);
        access("lw_err", 4'b0010, 32'h500, 0, 5, 32'h77777777, 1'b1, 6, 1'b0);

        // Reset during REQ
        push_bus(32'h600, 0, 4'b0000, 1'b0, 1'b0);
        IN_DATAMEMSEL = 1'b1;
        IN_READ_WRITE = 4'b0010;
        IN_ALU_RESULT = 32'h600;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #2;
        chk("pre_reset_req", {31'h0, MEM_REQ}, 32'h1);
        RESET_N = 1'b0;
        #1;
        chk("mid_reset_req", {31'h0, MEM_REQ}, 32'h0);
        chk("mid_reset_stall", {31'h0, OUT_STALL}, 32'h0);
        chk("mid_reset_load", OUT_LOAD_DATA, 32'h0);
        IN_DATAMEMSEL = 1'b0;
        @(negedge CLK);
        #1;
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;

`ifdef MEM_ACCESS_TIMEOUT_EN
        push_bus(32'h700, 0, 4'b0000, 1'b0, 1'b0); q_fault.push_back(32'h0);
        access("lw_tmo", 4'b0010, 32'h700, 0, 0, 0, 1'b0, 5, 1'b0);
`else
        push_bus(32'h700, 0, 4'b0000, 1'b0, 1'b0); q_load.push_back(32'h13579BDF);
        access("lw_long", 4'b0010, 32'h700, 0, 20, 32'h13579BDF, 1'b0, 21, 1'b1);
`endif

        push_bus(32'h104, 0, 4'b0000, 1'b0, 1'b0); q_load.push_back(32'h2468ACE0);
        access("lw_after", 4'b0010, 32'h104, 0, 1, 32'h2468ACE0, 1'b0, 2, 1'b1);

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("q_bus_left", q_bus.size(), 0);
        chk("q_load_left", q_load.size(), 0);
        chk("q_fault_left", q_fault.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_access_ctrl.md
# mem_stage_access_ctrl

Memory-stage controller sitting directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register. It takes the EX/MEM outputs (address, store data, access type), runs a request/ready transaction on the data-memory bus, and does byte/half/word alignment, store strobes and load sign/zero extension. It stalls the front of the pipeline while a transaction is outstanding and flags misaligned, illegal or errored accesses.

## Interface
- TIMEOUT_CYCLES, 16: REQ-state cycle budget before abort; used only with the timeout feature.
- CLK  in  1  rising-edge clock.
- RESET_N  in  1  asynchronous, active-low reset.
- IN_DATAMEMSEL  in  1  the current EX/MEM instruction is a load/store.
- IN_READ_WRITE  in  4  [3] = 1 store, 0 load; [2:0] = RISC-V funct3.
- IN_ALU_RESULT  in  32  byte address.
- IN_DATA2  in  32  store data (rs2).
- MEM_REQ  out  1  bus request.
- MEM_WE  out  1  write enable.
- MEM_ADDR  out  32  word-aligned address ({addr[31:2],2'b00}).
- MEM_WDATA  out  32  lane-shifted store data.
- MEM_WSTRB  out  4  byte strobes (0 for loads).
- MEM_RDATA  in  32  read word.
- MEM_READY  in  1  transaction complete.
- MEM_ERR  in  1  bus error, sampled only with MEM_READY.
- OUT_LOAD_DATA  out  32  aligned, extended load result.
- OUT_LOAD_VALID  out  1  one-cycle pulse when OUT_LOAD_DATA is updated.
- OUT_STALL  out  1  hold the PC, IF/ID, ID/EX and EX/MEM registers.
- OUT_FAULT  out  1  one-cycle pulse for misaligned, illegal, bus error or timeout.

## Operation
- States: IDLE, REQ, RESP.
- Supported funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other combination is illegal.
- IDLE, IN_DATAMEMSEL=1, access legal and aligned:
  - OUT_STALL=1 (combinational).
  - Register MEM_ADDR, MEM_WDATA, MEM_WSTRB and MEM_WE; set MEM_REQ=1; go to REQ.
- IDLE, access illegal or misaligned (halfword with addr[0]=1; word with addr[1:0]≠0):
  - No request and no stall.
  - OUT_FAULT pulses in the same cycle (combinational); stay in IDLE.
- REQ:
  - MEM_REQ and all bus outputs are held stable; OUT_STALL=1.
  - On MEM_READY: drop MEM_REQ and go to RESP.
  - For a load with MEM_ERR=0: register the extracted result into OUT_LOAD_DATA.
  - If MEM_ERR=1: register OUT_FAULT=1 and leave OUT_LOAD_DATA unchanged.
- RESP:
  - OUT_STALL=0, so EX/MEM advances at the end of this cycle.
  - OUT_LOAD_VALID=1 for a successful load. OUT_FAULT is set here if an error was registered.
  - Always go to IDLE. A new access is never started from RESP.
- Store alignment:
  - SB: data[7:0] replicated on all four lanes; strobe 0001<<addr[1:0].
  - SH: data[15:0] on both halves; strobe 0011<<addr[1:0].
  - SW: full word; strobe 1111.
- Load alignment:
  - Select byte or halfword by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- OUT_LOAD_DATA holds its value until the next successful load.

## Timing
- Reset (asynchronous, any state, including mid-transaction):
  - State IDLE.
  - MEM_REQ, MEM_WE, MEM_WSTRB, MEM_ADDR, MEM_WDATA = 0.
  - OUT_LOAD_DATA = 0; OUT_LOAD_VALID and OUT_FAULT = 0.
  - OUT_STALL = 0 after reset; it is driven combinationally from state and inputs.
  - Memory must discard an in-flight request when reset is asserted.
- With MEM_READY in the first REQ cycle:
  - Access presented in cycle 0, MEM_REQ high in cycle 1, RESP in cycle 2.
  - Two stall cycles (0 and 1); the load result is valid in cycle 2.
- Each extra wait cycle adds one stall cycle.
- MEM_READY while in IDLE or RESP is ignored.
- MEM_RDATA is sampled only on the REQ cycle in which MEM_READY=1.

## Configuration
- MEM_ACCESS_TIMEOUT_EN defined:
  - A clog2(TIMEOUT_CYCLES+1)-bit counter clears on entry to REQ and increments each REQ cycle without MEM_READY.
  - When the count reaches TIMEOUT_CYCLES: drop MEM_REQ, go to RESP with the fault registered, no load update.
- Not defined: no counter; REQ waits for MEM_READY indefinitely.

## Structure
- Package mem_stage_pkg holds:
  - Funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - The state enum (IDLE, REQ, RESP).
  - Strobe base constants.
- Sub-module load_align_unit (combinational): inputs rdata, addr[1:0], funct3; output is the 32-bit extended result. Instanced once in the REQ capture path.

## Test plan
- LW from 0x100, memory returns 0xDEADBEEF with MEM_READY in the first REQ cycle -> MEM_ADDR=0x100, stall for 2 cycles, OUT_LOAD_DATA=0xDEADBEEF with OUT_LOAD_VALID in cycle 2.
- LB from 0x103, rdata 0x80123456 -> OUT_LOAD_DATA=0xFFFFFF80. LBU, same case -> 0x00000080. LHU from 0x102 -> 0x00008012.
- SH of 0x0000ABCD to 0x206 -> MEM_ADDR=0x204, MEM_WSTRB=1100, MEM_WDATA=0xABCDABCD, MEM_WE=1.
- LW from 0x101 -> no MEM_REQ, OUT_FAULT pulses in cycle 0, OUT_STALL stays 0. Store with funct3=011 -> same response.
- MEM_READY delayed 5 cycles, then MEM_ERR=1 -> 6 stall cycles; OUT_FAULT in RESP; OUT_LOAD_DATA unchanged.
- RESET_N asserted while in REQ -> MEM_REQ=0 and OUT_STALL=0 immediately. With MEM_ACCESS_TIMEOUT_EN and TIMEOUT_CYCLES=4, no MEM_READY -> abort after 4 REQ cycles and OUT_FAULT in RESP.
